// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter for one shared single-port memory
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   if_req/if_addr              fetch request (held until if_ready)
//   if_rdata/if_ready           fetched word (registered), one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata/d_wstrb   data request (held until d_ready)
//   d_rdata/d_ready             load data (registered), one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb   registered copy of the granted access
//   mem_rdata/mem_ack           memory read data and completion
//   cpu_stall                   combinational: some request is pending without its ready
//   bus_err                     sticky, set when an access times out
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        cpu_stall,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Abort fires on the edge where the wait counter would reach TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic       last_grant;   // 1 = data port was served last
  logic [7:0] wait_cnt;
  logic       busy;
  logic       grant_if;
  logic       grant_d;
  logic       ack_done;
  logic       timed_out;

  assign busy      = (state == BUSY_IF) || (state == BUSY_D);
  assign cpu_stall = (if_req & ~if_ready) | (d_req & ~d_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    ack_done  = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the port not served last wins.
        if (if_req && (!d_req || last_grant)) begin
          grant_if  = 1'b1;
          state_nxt = BUSY_IF;
        end else if (d_req) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end
      end
      BUSY_IF, BUSY_D: begin
        // An ack on the timeout cycle takes priority over the abort.
        if (mem_ack) begin
          ack_done  = 1'b1;
          state_nxt = DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          timed_out = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wstrb  <= 4'h0;
      if_rdata   <= 32'h0;
      d_rdata    <= 32'h0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      bus_err    <= 1'b0;
      wait_cnt   <= 8'h0;
      last_grant <= 1'b1;
    end else begin
      // Ready is raised on entry to DONE, so it lasts exactly one cycle.
      if_ready <= 1'b0;
      d_ready  <= 1'b0;

      if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= 32'h0;
        mem_wstrb <= 4'h0;
        wait_cnt  <= 8'h0;
      end

      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_wstrb <= d_wstrb;
        wait_cnt  <= 8'h0;
      end

      if (busy && !mem_ack) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (ack_done || timed_out) begin
        mem_req    <= 1'b0;
        last_grant <= (state == BUSY_D);
        if (state == BUSY_D) begin
          d_rdata <= ack_done ? mem_rdata : ERR_DATA;
          d_ready <= 1'b1;
        end else begin
          if_rdata <= ack_done ? mem_rdata : ERR_DATA;
          if_ready <= 1'b1;
        end
        if (timed_out) begin
          bus_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [3:0]  d_wstrb = 4'h0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        cpu_stall;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .cpu_stall (cpu_stall),
    .bus_err   (bus_err)
  );

  typedef struct packed {
    logic        port_d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_if_rdata = 32'h0;
  logic [31:0] model_d_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic port_d, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic [31:0] rdata);
    exp_t e;
    e.port_d = port_d;
    e.addr   = addr;
    e.we     = we;
    e.wdata  = wdata;
    e.wstrb  = wstrb;
    e.rdata  = rdata;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    sb.delete();
    model_if_rdata = 32'h0;
    model_d_rdata  = 32'h0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Acts as the memory for one access: waits for mem_req, checks the latched
  // request against the scoreboard head, acks on busy cycle ack_at (0 = never),
  // then checks the ready pulse and both read-data registers.
  task automatic run_txn(input int ack_at, input logic [31:0] mdata,
                         output int wait_cyc, output int busy_cyc);
    exp_t e;
    int   t;
    logic seen_ready;
    e = sb[0];
    t = 0;
    while (!mem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    wait_cyc = t;
    check("mem_req_up", {31'h0, mem_req}, 32'h1);
    check("mem_we", {31'h0, mem_we}, {31'h0, e.we});
    check("mem_addr", mem_addr, e.addr);
    check("mem_wdata", mem_wdata, e.wdata);
    check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, e.wstrb});
    check("stall_busy", {31'h0, cpu_stall}, 32'h1);
    busy_cyc   = 0;
    seen_ready = 1'b0;
    for (int k = 0; k < 40 && !seen_ready; k++) begin
      busy_cyc++;
      mem_ack   = (busy_cyc == ack_at);
      mem_rdata = (busy_cyc == ack_at) ? mdata : 32'h0BAD0BAD;
      @(negedge clk);
      seen_ready = if_ready | d_ready;
    end
    mem_ack = 1'b0;
    check("ready_seen", {31'h0, seen_ready}, 32'h1);
    check("if_ready_port", {31'h0, if_ready}, {31'h0, ~e.port_d});
    check("d_ready_port", {31'h0, d_ready}, {31'h0, e.port_d});
    check("mem_req_down", {31'h0, mem_req}, 32'h0);
    if (e.port_d) model_d_rdata = e.rdata;
    else          model_if_rdata = e.rdata;
    check("if_rdata", if_rdata, model_if_rdata);
    check("d_rdata", d_rdata, model_d_rdata);
    void'(sb.pop_front());
  endtask

  initial begin
    int w;
    int b;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_if_ready", {31'h0, if_ready}, 32'h0);
    check("rst_d_ready", {31'h0, d_ready}, 32'h0);
    check("rst_bus_err", {31'h0, bus_err}, 32'h0);
    check("rst_stall", {31'h0, cpu_stall}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single fetch with minimum latency
    if_req  = 1'b1;
    if_addr = 32'h100;
    push_exp(1'b0, 32'h100, 1'b0, 32'h0, 4'h0, 32'h00500093);
    run_txn(1, 32'h00500093, w, b);
    check("fetch_grant_lat", 32'(w), 32'd1);
    check("fetch_busy_cyc", 32'(b), 32'd1);
    if_req = 1'b0;
    @(negedge clk);
    check("fetch_ready_pulse", {31'h0, if_ready}, 32'h0);
    check("fetch_stall_clr", {31'h0, cpu_stall}, 32'h0);

    // Tie after reset: fetch first, then the store
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h104;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h2000;
    d_wdata = 32'h12345678;
    d_wstrb = 4'hF;
    #1;
    check("tie_stall", {31'h0, cpu_stall}, 32'h1);
    push_exp(1'b0, 32'h104, 1'b0, 32'h0, 4'h0, 32'h11111111);
    push_exp(1'b1, 32'h2000, 1'b1, 32'h12345678, 4'hF, 32'h22222222);
    run_txn(1, 32'h11111111, w, b);
    check("tie_stall_d_pending", {31'h0, cpu_stall}, 32'h1);
    if_req = 1'b0;
    run_txn(2, 32'h22222222, w, b);
    check("store_busy_cyc", 32'(b), 32'd2);
    d_req = 1'b0;
    @(negedge clk);
    check("store_stall_clr", {31'h0, cpu_stall}, 32'h0);

    // Round-robin with both requests held: IF, D, IF, D
    if_req  = 1'b1;
    if_addr = 32'h200;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h3000;
    d_wdata = 32'h0;
    d_wstrb = 4'h0;
    push_exp(1'b0, 32'h200, 1'b0, 32'h0, 4'h0, 32'hA1A1A1A1);
    push_exp(1'b1, 32'h3000, 1'b0, 32'h0, 4'h0, 32'hB1B1B1B1);
    push_exp(1'b0, 32'h200, 1'b0, 32'h0, 4'h0, 32'hA2A2A2A2);
    push_exp(1'b1, 32'h3000, 1'b0, 32'h0, 4'h0, 32'hB2B2B2B2);
    run_txn(1, 32'hA1A1A1A1, w, b);
    run_txn(2, 32'hB1B1B1B1, w, b);
    run_txn(1, 32'hA2A2A2A2, w, b);
    run_txn(3, 32'hB2B2B2B2, w, b);
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);

    // Timeout: no ack ever
    d_req  = 1'b1;
    d_addr = 32'h4000;
    push_exp(1'b1, 32'h4000, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF);
    run_txn(0, 32'h0, w, b);
    check("to_busy_cyc", 32'(b), 32'd4);
    check("to_bus_err", {31'h0, bus_err}, 32'h1);
    d_req = 1'b0;
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h300;
    push_exp(1'b0, 32'h300, 1'b0, 32'h0, 4'h0, 32'h33333333);
    run_txn(1, 32'h33333333, w, b);
    check("to_bus_err_sticky", {31'h0, bus_err}, 32'h1);
    if_req = 1'b0;
    @(negedge clk);

    // mem_ack while idle is ignored
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF0000;
    repeat (3) @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack_mem_req", {31'h0, mem_req}, 32'h0);
    check("idle_ack_ready", {30'h0, if_ready, d_ready}, 32'h0);
    check("idle_ack_if_rdata", if_rdata, model_if_rdata);
    check("idle_ack_d_rdata", d_rdata, model_d_rdata);

    // Ack on the timeout cycle wins
    do_reset();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h5000;
    push_exp(1'b1, 32'h5000, 1'b0, 32'h0, 4'h0, 32'hCAFEF00D);
    run_txn(4, 32'hCAFEF00D, w, b);
    check("ack_to_busy_cyc", 32'(b), 32'd4);
    check("ack_to_bus_err", {31'h0, bus_err}, 32'h0);
    d_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of a store
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h6000;
    d_wdata = 32'hA5A5A5A5;
    d_wstrb = 4'h3;
    @(negedge clk);
    check("mid_mem_req_up", {31'h0, mem_req}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_mem_req", {31'h0, mem_req}, 32'h0);
    check("mid_mem_we", {31'h0, mem_we}, 32'h0);
    check("mid_mem_addr", mem_addr, 32'h0);
    check("mid_mem_wdata", mem_wdata, 32'h0);
    check("mid_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    check("mid_d_rdata", d_rdata, 32'h0);
    check("mid_d_ready", {31'h0, d_ready}, 32'h0);
    @(negedge clk);
    check("mid_no_ready", {30'h0, if_ready, d_ready}, 32'h0);
    check("mid_mem_req_held", {31'h0, mem_req}, 32'h0);
    d_req = 1'b0;
    sb.delete();
    model_if_rdata = 32'h0;
    model_d_rdata  = 32'h0;
    rst = 1'b1;
    @(negedge clk);
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h7000;
    d_wdata = 32'h0;
    d_wstrb = 4'h0;
    push_exp(1'b1, 32'h7000, 1'b0, 32'h0, 4'h0, 32'h77777777);
    run_txn(1, 32'h77777777, w, b);
    check("post_rst_grant_lat", 32'(w), 32'd1);
    check("post_rst_busy_cyc", 32'(b), 32'd1);
    d_req = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, range 1..255: max cycles in a busy state without mem_ack before abort.
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF: read data returned on a timed-out access.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately, independent of clk.
REQ-005 if_req  input  1  instruction-fetch request, held high until if_ready.
REQ-006 if_addr  input  32  fetch byte address, stable while if_req=1.
REQ-007 if_rdata  output  32  fetched word, registered.
REQ-008 if_ready  output  1  one-cycle completion pulse for fetch.
REQ-009 d_req  input  1  data-access request, held high until d_ready.
REQ-010 d_we  input  1  1=store, 0=load.
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_wstrb  input  4  store byte enables.
REQ-014 d_rdata  output  32  load data, registered.
REQ-015 d_ready  output  1  one-cycle completion pulse for data.
REQ-016 mem_req  output  1  request to the shared single-port memory, registered.
REQ-017 mem_we, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]  output  latched copy of granted request; mem_we=0 and mem_wstrb=0 for fetch.
REQ-018 mem_rdata  input  32  memory read data, valid when mem_ack=1.
REQ-019 mem_ack  input  1  memory completion, sampled only while mem_req=1.
REQ-020 cpu_stall  output  1  combinational: (if_req & ~if_ready) | (d_req & ~d_ready).
REQ-021 bus_err  output  1  sticky flag, set on any timeout.

Function
REQ-022 States: IDLE, BUSY_IF, BUSY_D, DONE; 2-bit encoding, registered.
REQ-023 IDLE: if only one request high, grant it; if both high, grant the port not granted last (last_grant bit); no request -> stay IDLE.
REQ-024 On grant, the arbiter latches address, we, wdata, wstrb (fetch: we=0, wstrb=0) into the mem_* registers, sets mem_req=1 and enters BUSY_IF/BUSY_D, all in the same edge.
REQ-025 BUSY_x: mem_req held high, mem_* stable; on mem_ack=1, mem_rdata is captured into x_rdata, mem_req cleared, last_grant updated to x, and the next state is DONE.
REQ-026 DONE: x_ready=1 for exactly one cycle, then IDLE; the requester not served in DONE is not granted until IDLE.
REQ-027 Minimum latency: req high at edge t -> mem_req at t+1 -> mem_ack at t+1 -> ready high in cycle t+2..t+3 (three edges req-to-ready).
REQ-028 A requester's req held through its ready cycle is treated as a new request in the following IDLE cycle (back-to-back allowed).
REQ-029 Wait counter, 8 bits: cleared on grant; increments each BUSY cycle without mem_ack; on reaching TIMEOUT, the arbiter clears mem_req, loads ERR_DATA into x_rdata, sets bus_err and enters DONE.
REQ-030 mem_ack in the same cycle the counter reaches TIMEOUT: ack wins; data is taken from mem_rdata and bus_err is not set.
REQ-031 mem_ack outside BUSY states is ignored.
REQ-032 x_rdata holds its value until that port's next completion.
REQ-033 Requests dropped before ready: protocol violation; the granted access still completes and ready still pulses.

Reset
REQ-034 rst=0 asynchronously forces: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, if_rdata=0, d_rdata=0, if_ready=0, d_ready=0, bus_err=0, counter=0, last_grant=data (fetch wins the first tie).
REQ-035 Reset asserted mid-access aborts it without a ready pulse; mem_req falls in the same cycle, before the next clk edge.

Verification
REQ-036 Single fetch: if_req=1, if_addr=0x100, mem_ack one cycle after mem_req with mem_rdata=0x00500093 -> if_rdata=0x00500093, if_ready one cycle, mem_we=0.
REQ-037 Tie after reset: if_req=d_req=1 at the same edge -> fetch served first, then store d_addr=0x2000, d_wdata=0x12345678, d_wstrb=0xF appears on mem_* with mem_we=1; cpu_stall=1 until d_ready.
REQ-038 Round-robin: both requests held continuously for 4 completions -> grant order IF, D, IF, D.
REQ-039 Timeout, TIMEOUT=4: mem_ack never asserted -> mem_req drops after 4 busy cycles, d_rdata=0xDEADBEEF, d_ready pulses, bus_err=1 and stays 1.
REQ-040 Ack on the timeout cycle: mem_ack=1 with mem_rdata=0xCAFEF00D on the 4th busy cycle -> data=0xCAFEF00D, bus_err=0.
REQ-041 Reset mid-access: rst=0 while in BUSY_D -> mem_req=0 before the next clk edge, no d_ready, all outputs at reset values; the first request after reset is served normally.
